amba3_axi_wr_slave: RTL and testbench

Synthesizable AMBA3 AXI write-channel responder (AW/W/B) backed by an internal word-addressed RAM; the RTL counterpart to the verification master on the write path. Accepts one write burst at a time, commits byte-strobed data, returns a B response. A combinational debug port gives the bench direct read-back of RAM contents.

---
 rtl/amba3_axi_wr_slave_if.sv | 45 ++++
 rtl/amba3_axi_wr_slave.sv | 233 +++++++++++++++++++++++
 tb/tb_amba3_axi_wr_slave.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/amba3_axi_wr_slave_if.sv
// AMBA3 AXI write-channel bundle (AW/W/B).
// The master drives requests and write data; the slave returns ready and B response signals.
interface amba3_axi_wr_slave_if #(
  parameter int AXID_SIZE = 4,
  parameter int ADDR_SIZE = 32,
  parameter int DATA_SIZE = 128
);
  logic [AXID_SIZE-1:0]   awid;
  logic [ADDR_SIZE-1:0]   awaddr;
  logic [3:0]             awlen;
  logic [2:0]             awsize;
  logic [1:0]             awburst;
  logic                   awvalid;
  logic                   awready;

  logic [AXID_SIZE-1:0]   wid;
  logic [DATA_SIZE-1:0]   wdata;
  logic [DATA_SIZE/8-1:0] wstrb;
  logic                   wlast;
  logic                   wvalid;
  logic                   wready;

  logic [AXID_SIZE-1:0]   bid;
  logic [1:0]             bresp;
  logic                   bvalid;
  logic                   bready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/amba3_axi_wr_slave.sv
// AXI3 write responder: accepts one burst at a time into a word-addressed RAM.
// Returns a B response and exposes a combinational debug read port.
module amba3_axi_wr_slave #(
  parameter int AXID_SIZE = 4,
  parameter int ADDR_SIZE = 32,
  parameter int DATA_SIZE = 128,
  parameter int MEM_DEPTH = 256
) (
  input  logic                         aclk,
  input  logic                         areset_n,
  amba3_axi_wr_slave_if.slave          axi,
  input  logic [$clog2(MEM_DEPTH)-1:0] dbg_addr,
  output logic [DATA_SIZE-1:0]         dbg_rdata
);

  localparam int STRB  = DATA_SIZE / 8;
  localparam int LSB   = $clog2(STRB);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [2:0] MAX_SIZE = 3'(LSB);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    RESP
  } state_e;

  state_e                 state_q, state_d;
  logic [AXID_SIZE-1:0]   id_q, id_d;
  logic [ADDR_SIZE-1:0]   addr_q, addr_d;
  logic [3:0]             len_q, len_d;
  logic [2:0]             size_q, size_d;
  logic [1:0]             burst_q, burst_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [1:0]             err_q, err_d;
  logic                   awready_q, awready_d;
  logic                   wready_q, wready_d;
  logic                   bvalid_q, bvalid_d;
  logic [AXID_SIZE-1:0]   bid_q, bid_d;
  logic [1:0]             bresp_q, bresp_d;

  logic [DATA_SIZE-1:0]   mem [MEM_DEPTH];

  logic [ADDR_SIZE-1:0]   aw_size_mask;
  logic                   aw_wrap_len_ok;
  logic                   aw_slverr;
  logic                   aw_decerr;
  logic [1:0]             aw_err;

  logic [ADDR_SIZE-1:0]   size_bytes;
  logic [2:0]             wrap_shift;
  logic [ADDR_SIZE-1:0]   wrap_mask;
  logic [ADDR_SIZE-1:0]   incr_next;
  logic [ADDR_SIZE-1:0]   wrap_next;
  logic [ADDR_SIZE-1:0]   next_addr;
  logic                   beat_in_range;
  logic                   beat_last;
  logic                   beat_proto_err;
  logic [1:0]             beat_err;
  logic                   w_hs;
  logic                   mem_we;
  logic [IDX_W-1:0]       mem_idx;

  // Decode of the incoming AW request; DECERR takes priority over SLVERR.
  always_comb begin
    aw_size_mask   = (ADDR_SIZE'(1) << axi.awsize) - ADDR_SIZE'(1);
    aw_wrap_len_ok = (axi.awlen == 4'd1) || (axi.awlen == 4'd3) ||
                     (axi.awlen == 4'd7) || (axi.awlen == 4'd15);
    aw_slverr      = (axi.awsize > MAX_SIZE) ||
                     (axi.awburst == 2'b11) ||
                     ((axi.awburst == BURST_WRAP) &&
                      (!aw_wrap_len_ok || ((axi.awaddr & aw_size_mask) != '0)));
    aw_decerr      = (axi.awaddr >> (LSB + IDX_W)) != '0;
    if (aw_decerr) begin
      aw_err = RESP_DECERR;
    end else if (aw_slverr) begin
      aw_err = RESP_SLVERR;
    end else begin
      aw_err = RESP_OKAY;
    end
  end

  // Per-beat address stepping, range check and protocol checks.
  always_comb begin
    size_bytes = ADDR_SIZE'(1) << size_q;
    case (len_q)
      4'd1:    wrap_shift = 3'd1;
      4'd3:    wrap_shift = 3'd2;
      4'd7:    wrap_shift = 3'd3;
      default: wrap_shift = 3'd4;
    endcase
    wrap_mask = (size_bytes << wrap_shift) - ADDR_SIZE'(1);
    incr_next = (addr_q & ~(size_bytes - ADDR_SIZE'(1))) + size_bytes;
    wrap_next = (addr_q & ~wrap_mask) | ((addr_q + size_bytes) & wrap_mask);
    case (burst_q)
      BURST_INCR: next_addr = incr_next;
      BURST_WRAP: next_addr = wrap_next;
      default:    next_addr = addr_q;
    endcase

    beat_in_range  = (addr_q >> (LSB + IDX_W)) == '0;
    mem_idx        = addr_q[LSB +: IDX_W];
    beat_last      = (cnt_q == len_q);
    beat_proto_err = (axi.wid != id_q) || (axi.wlast != beat_last);
    w_hs           = wready_q && axi.wvalid;

    beat_err = err_q;
    if (err_q == RESP_OKAY) begin
      if (!beat_in_range) begin
        beat_err = RESP_DECERR;
      end else if (beat_proto_err) begin
        beat_err = RESP_SLVERR;
      end
    end
    mem_we = w_hs && (err_q == RESP_OKAY) && beat_in_range && !beat_proto_err;
  end

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    addr_d    = addr_q;
    len_d     = len_q;
    size_d    = size_q;
    burst_d   = burst_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bid_d     = bid_q;
    bresp_d   = bresp_q;

    case (state_q)
      IDLE: begin
        awready_d = 1'b1;
        if (awready_q && axi.awvalid) begin
          id_d      = axi.awid;
          addr_d    = axi.awaddr;
          len_d     = axi.awlen;
          size_d    = axi.awsize;
          burst_d   = axi.awburst;
          cnt_d     = 4'd0;
          err_d     = aw_err;
          awready_d = 1'b0;
          wready_d  = 1'b1;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (w_hs) begin
          err_d  = beat_err;
          addr_d = next_addr;
          cnt_d  = cnt_q + 4'd1;
          if (beat_last) begin
            wready_d = 1'b0;
            bvalid_d = 1'b1;
            bid_d    = id_q;
            bresp_d  = beat_err;
            state_d  = RESP;
          end
        end
      end
      RESP: begin
        if (axi.bready) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_q   <= IDLE;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= BURST_FIXED;
      cnt_q     <= '0;
      err_q     <= RESP_OKAY;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= RESP_OKAY;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
    end
  end

  // RAM has no reset so committed beats survive an abandoned burst.
  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int i = 0; i < STRB; i++) begin
        if (axi.wstrb[i]) begin
          mem[mem_idx][8*i +: 8] <= axi.wdata[8*i +: 8];
        end
      end
    end
  end

  assign dbg_rdata   = mem[dbg_addr];
  assign axi.awready = awready_q;
  assign axi.wready  = wready_q;
  assign axi.bvalid  = bvalid_q;
  assign axi.bid     = bid_q;
  assign axi.bresp   = bresp_q;

endmodule

// File: tb/tb_amba3_axi_wr_slave.sv
// Directed bench for amba3_axi_wr_slave: drives bursts on negedges, samples on negedges,
// and checks handshakes, B responses and RAM contents through the debug port.
module tb_amba3_axi_wr_slave;

  localparam int AXID_SIZE = 4;
  localparam int ADDR_SIZE = 32;
  localparam int DATA_SIZE = 128;
  localparam int MEM_DEPTH = 256;
  localparam int STRB      = DATA_SIZE / 8;

  logic                 aclk     = 1'b0;
  logic                 areset_n = 1'b0;
  logic [7:0]           dbg_addr;
  logic [DATA_SIZE-1:0] dbg_rdata;

  int compared   = 0;
  int mismatched = 0;

  logic [DATA_SIZE-1:0] beat_data [16];
  logic [STRB-1:0]      beat_strb [16];

  amba3_axi_wr_slave_if #(
    .AXID_SIZE(AXID_SIZE),
    .ADDR_SIZE(ADDR_SIZE),
    .DATA_SIZE(DATA_SIZE)
  ) axi_if ();

  amba3_axi_wr_slave #(
    .AXID_SIZE(AXID_SIZE),
    .ADDR_SIZE(ADDR_SIZE),
    .DATA_SIZE(DATA_SIZE),
    .MEM_DEPTH(MEM_DEPTH)
  ) dut (
    .aclk      (aclk),
    .areset_n  (areset_n),
    .axi       (axi_if.slave),
    .dbg_addr  (dbg_addr),
    .dbg_rdata (dbg_rdata)
  );

  always #5 aclk = ~aclk;

  // Every comparison in the bench is routed through here.
  task automatic checkOutput(input string tag, input logic [DATA_SIZE-1:0] observed,
                             input logic [DATA_SIZE-1:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkMem(input string tag, input int idx, input logic [DATA_SIZE-1:0] expected);
    dbg_addr = 8'(idx);
    #1;
    checkOutput(tag, dbg_rdata, expected);
  endtask

  task automatic setBeat(input int i, input logic [DATA_SIZE-1:0] data, input logic [STRB-1:0] strb);
    beat_data[i] = data;
    beat_strb[i] = strb;
  endtask

  task automatic sendAw(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                        input logic [2:0] size, input logic [1:0] burst);
    int n;
    axi_if.awid    = id;
    axi_if.awaddr  = addr;
    axi_if.awlen   = len;
    axi_if.awsize  = size;
    axi_if.awburst = burst;
    axi_if.awvalid = 1'b1;
    n = 0;
    while (axi_if.awready !== 1'b1 && n < 20) begin
      @(negedge aclk);
      n++;
    end
    checkOutput("awready", {127'd0, axi_if.awready}, 128'd1);
    @(negedge aclk);
    axi_if.awvalid = 1'b0;
  endtask

  task automatic sendBeat(input logic [3:0] wid, input int i, input logic last);
    int n;
    axi_if.wid    = wid;
    axi_if.wdata  = beat_data[i];
    axi_if.wstrb  = beat_strb[i];
    axi_if.wlast  = last;
    axi_if.wvalid = 1'b1;
    n = 0;
    while (axi_if.wready !== 1'b1 && n < 20) begin
      @(negedge aclk);
      n++;
    end
    checkOutput("wready", {127'd0, axi_if.wready}, 128'd1);
    @(negedge aclk);
    axi_if.wvalid = 1'b0;
    axi_if.wlast  = 1'b0;
  endtask

  // Full burst: AW, len+1 beats, optional B stall, then B handshake and awready return.
  task automatic applyStimulus(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                               input logic [2:0] size, input logic [1:0] burst,
                               input int bad_wid_beat, input int stall, input logic [1:0] exp_resp);
    int n;
    sendAw(id, addr, len, size, burst);
    for (int i = 0; i <= int'(len); i++) begin
      sendBeat((i == bad_wid_beat) ? (id ^ 4'h1) : id, i, (i == int'(len)));
    end
    n = 0;
    while (axi_if.bvalid !== 1'b1 && n < 20) begin
      @(negedge aclk);
      n++;
    end
    checkOutput("bvalid", {127'd0, axi_if.bvalid}, 128'd1);
    checkOutput("bid", {124'd0, axi_if.bid}, {124'd0, id});
    checkOutput("bresp", {126'd0, axi_if.bresp}, {126'd0, exp_resp});
    for (int c = 0; c < stall; c++) begin
      @(negedge aclk);
      checkOutput("stall_bvalid", {127'd0, axi_if.bvalid}, 128'd1);
      checkOutput("stall_bid", {124'd0, axi_if.bid}, {124'd0, id});
      checkOutput("stall_bresp", {126'd0, axi_if.bresp}, {126'd0, exp_resp});
      checkOutput("stall_awready", {127'd0, axi_if.awready}, 128'd0);
    end
    axi_if.bready = 1'b1;
    @(negedge aclk);
    axi_if.bready = 1'b0;
    checkOutput("bvalid_clear", {127'd0, axi_if.bvalid}, 128'd0);
    checkOutput("awready_after_b", {127'd0, axi_if.awready}, 128'd1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    axi_if.awid    = '0;
    axi_if.awaddr  = '0;
    axi_if.awlen   = '0;
    axi_if.awsize  = '0;
    axi_if.awburst = '0;
    axi_if.awvalid = 1'b0;
    axi_if.wid     = '0;
    axi_if.wdata   = '0;
    axi_if.wstrb   = '0;
    axi_if.wlast   = 1'b0;
    axi_if.wvalid  = 1'b0;
    axi_if.bready  = 1'b0;
    dbg_addr       = '0;
    for (int i = 0; i < 16; i++) setBeat(i, '0, '1);

    // Reset values, then awready rises after exactly one edge.
    repeat (3) @(negedge aclk);
    checkOutput("rst_awready", {127'd0, axi_if.awready}, 128'd0);
    checkOutput("rst_wready", {127'd0, axi_if.wready}, 128'd0);
    checkOutput("rst_bvalid", {127'd0, axi_if.bvalid}, 128'd0);
    checkOutput("rst_bresp", {126'd0, axi_if.bresp}, 128'd0);
    checkOutput("rst_bid", {124'd0, axi_if.bid}, 128'd0);
    areset_n = 1'b1;
    #1;
    checkOutput("awready_pre_edge", {127'd0, axi_if.awready}, 128'd0);
    @(negedge aclk);
    checkOutput("awready_post_edge", {127'd0, axi_if.awready}, 128'd1);

    // INCR burst into words 2..5.
    for (int i = 0; i < 4; i++) setBeat(i, {4{32'h1100_0000 + i}}, '1);
    applyStimulus(4'd3, 32'h20, 4'd3, 3'd4, 2'b01, -1, 0, 2'b00);
    checkMem("incr_w2", 2, {4{32'h1100_0000}});
    checkMem("incr_w3", 3, {4{32'h1100_0001}});
    checkMem("incr_w4", 4, {4{32'h1100_0002}});
    checkMem("incr_w5", 5, {4{32'h1100_0003}});

    // Preload word 0, then partial strobes via a FIXED burst.
    setBeat(0, {16{8'h55}}, '1);
    applyStimulus(4'd0, 32'h0, 4'd0, 3'd4, 2'b00, -1, 0, 2'b00);
    checkMem("preload_w0", 0, {16{8'h55}});
    setBeat(0, 128'h00112233_44556677_8899AABB_CCDDEEFF, 16'h000F);
    setBeat(1, 128'hFFEEDDCC_BBAA9988_77665544_33221100, 16'hF000);
    applyStimulus(4'd1, 32'h0, 4'd1, 3'd4, 2'b00, -1, 0, 2'b00);
    checkMem("strobe_w0", 0, 128'hFFEEDDCC_55555555_55555555_CCDDEEFF);

    // WRAP len=3 from 0x30 visits words 3,0,1,2.
    for (int i = 0; i < 4; i++) setBeat(i, {4{32'h3300_0000 + i}}, '1);
    applyStimulus(4'd4, 32'h30, 4'd3, 3'd4, 2'b10, -1, 0, 2'b00);
    checkMem("wrap_w3", 3, {4{32'h3300_0000}});
    checkMem("wrap_w0", 0, {4{32'h3300_0001}});
    checkMem("wrap_w1", 1, {4{32'h3300_0002}});
    checkMem("wrap_w2", 2, {4{32'h3300_0003}});

    // Out-of-range start address: DECERR and word 0 untouched.
    setBeat(0, {4{32'hDEAD_BEEF}}, '1);
    applyStimulus(4'd6, 32'h1000, 4'd0, 3'd4, 2'b01, -1, 0, 2'b11);
    checkMem("decerr_w0", 0, {4{32'h3300_0001}});

    // Oversized beat: SLVERR and word 4 untouched.
    applyStimulus(4'd7, 32'h40, 4'd0, 3'd5, 2'b01, -1, 0, 2'b10);
    checkMem("slverr_size_w4", 4, {4{32'h1100_0002}});

    // Wrong wid on beat 1: SLVERR, bid still the AW id, beat 0 committed.
    for (int i = 0; i < 2; i++) setBeat(i, {4{32'h6600_0000 + i}}, '1);
    applyStimulus(4'd5, 32'h60, 4'd1, 3'd4, 2'b01, 1, 0, 2'b10);
    checkMem("widerr_w6", 6, {4{32'h6600_0000}});

    // B backpressure for 5 cycles, then a back-to-back AW the cycle after B.
    setBeat(0, {4{32'h8800_0000}}, '1);
    applyStimulus(4'd9, 32'h80, 4'd0, 3'd4, 2'b01, -1, 5, 2'b00);
    setBeat(0, {4{32'h9900_0000}}, '1);
    applyStimulus(4'd2, 32'h90, 4'd0, 3'd4, 2'b01, -1, 0, 2'b00);
    checkMem("bp_w8", 8, {4{32'h8800_0000}});
    checkMem("bp_w9", 9, {4{32'h9900_0000}});

    // Reset mid-burst: no B, committed beats persist.
    for (int i = 0; i < 4; i++) setBeat(i, {4{32'hAA00_0000 + i}}, '1);
    @(negedge aclk);
    sendAw(4'd1, 32'hA0, 4'd3, 3'd4, 2'b01);
    sendBeat(4'd1, 0, 1'b0);
    sendBeat(4'd1, 1, 1'b0);
    areset_n = 1'b0;
    #1;
    checkOutput("midrst_awready", {127'd0, axi_if.awready}, 128'd0);
    checkOutput("midrst_wready", {127'd0, axi_if.wready}, 128'd0);
    checkOutput("midrst_bvalid", {127'd0, axi_if.bvalid}, 128'd0);
    @(negedge aclk);
    areset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge aclk);
      checkOutput("midrst_no_b", {127'd0, axi_if.bvalid}, 128'd0);
    end
    checkOutput("midrst_awready_back", {127'd0, axi_if.awready}, 128'd1);
    checkMem("midrst_w10", 10, {4{32'hAA00_0000}});
    checkMem("midrst_w11", 11, {4{32'hAA00_0001}});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
